// File: rtl/bubble_sorter.sv
// rtl/bubble_sorter.sv - in-place bubble sorter over an internal synchronous RAM
// Host port owns the RAM while idle; START runs an early-exit, shrinking-window bubble sort.
module bubble_sorter #(
  parameter int W      = 8,
  parameter int N_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  desc,
  input  logic                  hwe,
  input  logic [N_LOG2-1:0]     haddr,
  input  logic [W-1:0]          hdata,
  output logic [W-1:0]          hq,
  output logic                  busy,
  output logic                  done,
  output logic [N_LOG2:0]       passes,
  output logic [2*N_LOG2-1:0]   swaps
);

  localparam int N = 1 << N_LOG2;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LAT, EVAL, WR_A, WR_B, PASS_END} state_t;

  state_t              state, state_nxt;
  logic [W-1:0]        mem [N];
  logic [W-1:0]        ram_q, ram_wd, a, b;
  logic [N_LOG2-1:0]   ram_addr, i, last;
  logic                ram_we, desc_q, swapped;
  logic                out_of_order, at_last, finish;

  // Strict comparison keeps equal elements in place, making the sort stable.
  assign out_of_order = desc_q ? (a < b) : (a > b);
  assign at_last      = (i == last);
  assign finish       = !swapped || (last == '0);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = RD_A;
      RD_A:     state_nxt = RD_B;
      RD_B:     state_nxt = LAT;
      LAT:      state_nxt = EVAL;
      EVAL:     state_nxt = out_of_order ? WR_A : (at_last ? PASS_END : RD_A);
      WR_A:     state_nxt = WR_B;
      WR_B:     state_nxt = at_last ? PASS_END : RD_A;
      PASS_END: state_nxt = finish ? IDLE : RD_A;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = i;
    ram_we   = 1'b0;
    ram_wd   = b;
    case (state)
      IDLE: begin
        ram_addr = haddr;
        ram_we   = hwe;
        ram_wd   = hdata;
      end
      RD_B:    ram_addr = i + 1'b1;
      WR_A:    ram_we   = 1'b1;
      WR_B: begin
        ram_addr = i + 1'b1;
        ram_we   = 1'b1;
        ram_wd   = a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hq      <= '0;
      done    <= 1'b0;
      passes  <= '0;
      swaps   <= '0;
      i       <= '0;
      last    <= '0;
      desc_q  <= 1'b0;
      swapped <= 1'b0;
      a       <= '0;
      b       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          hq <= ram_q;
          if (start) begin
            desc_q  <= desc;
            i       <= '0;
            last    <= N_LOG2'(N - 2);
            passes  <= '0;
            swaps   <= '0;
            swapped <= 1'b0;
          end
        end
        RD_B: a <= ram_q;
        LAT:  b <= ram_q;
        EVAL: begin
          if (out_of_order) begin
            swapped <= 1'b1;
            swaps   <= swaps + 1'b1;
          end else if (!at_last) begin
            i <= i + 1'b1;
          end
        end
        WR_B: if (!at_last) i <= i + 1'b1;
        PASS_END: begin
          passes <= passes + 1'b1;
          if (finish) begin
            done <= 1'b1;
          end else begin
            last    <= last - 1'b1;
            i       <= '0;
            swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sorter.sv
// tb/tb_bubble_sorter.sv - randomized self-checking bench for bubble_sorter
// Expected results come from a queue-based reference model of the sort statistics.
module tb_bubble_sorter;
  localparam int W  = 8;
  localparam int NL = 4;
  localparam int N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, desc, hwe;
  logic [NL-1:0] haddr;
  logic [W-1:0]  hdata, hq;
  logic          busy, done;
  logic [NL:0]   passes;
  logic [2*NL-1:0] swaps;

  logic          start1, hwe1, busy1, done1;
  logic [0:0]    haddr1;
  logic [W-1:0]  hdata1, hq1;
  logic [1:0]    passes1, swaps1;

  bubble_sorter #(.W(W), .N_LOG2(NL)) u_dut (
    .clk(clk), .rst(rst), .start(start), .desc(desc), .hwe(hwe), .haddr(haddr),
    .hdata(hdata), .hq(hq), .busy(busy), .done(done), .passes(passes), .swaps(swaps)
  );

  bubble_sorter #(.W(W), .N_LOG2(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .desc(1'b0), .hwe(hwe1), .haddr(haddr1),
    .hdata(hdata1), .hq(hq1), .busy(busy1), .done(done1), .passes(passes1), .swaps(swaps1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bubble sort with early exit: an element needing k moves left finishes after k passes,
  // one more swap-free pass confirms, capped at N-1 passes.
  task automatic model(input int v[$], input bit d, output int s[$], output int p,
                       output int sw, output int cyc);
    int n, maxl;
    n = v.size();
    sw = 0;
    maxl = 0;
    for (int j = 0; j < n; j++) begin
      int cnt;
      cnt = 0;
      for (int k = 0; k < j; k++)
        if (d ? (v[k] < v[j]) : (v[k] > v[j])) cnt++;
      sw += cnt;
      if (cnt > maxl) maxl = cnt;
    end
    p = (maxl + 1 > n - 1) ? n - 1 : maxl + 1;
    cyc = 2 * sw;
    for (int q = 0; q < p; q++) cyc += 4 * (n - 1 - q) + 1;
    s = v;
    if (d) s.rsort();
    else   s.sort();
  endtask

  task automatic load(input int v[$]);
    for (int k = 0; k < v.size(); k++) begin
      haddr = NL'(k);
      hdata = W'(v[k]);
      hwe   = 1'b1;
      step();
    end
    hwe = 1'b0;
  endtask

  task automatic read_all(output int r[$]);
    r = {};
    for (int k = 0; k < N; k++) begin
      haddr = NL'(k);
      step();
      step();
      r.push_back(int'(hq));
    end
  endtask

  task automatic run_sort(input bit d, input int lock_at, output int cyc, output int dn);
    start = 1'b1;
    desc  = d;
    step();
    start = 1'b0;
    cyc = 0;
    dn  = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      if (done) dn++;
      if (cyc == lock_at) begin
        start = 1'b1;
        hwe   = 1'b1;
        haddr = '0;
        hdata = 8'hFF;
      end
      step();
      start = 1'b0;
      hwe   = 1'b0;
    end
    if (cyc >= 5000) check("sort_timeout", 1, 0);
    check("done_at_busy_fall", done, 1);
    if (done) dn++;
    step();
    if (done) dn++;
  endtask

  task automatic full_test(input string tag, input int v[$], input bit d, input int lock_at);
    int s[$], r[$];
    int p, sw, cyc, mcyc, dn;
    load(v);
    model(v, d, s, p, sw, mcyc);
    run_sort(d, lock_at, cyc, dn);
    read_all(r);
    for (int k = 0; k < N; k++) check($sformatf("%s_data%0d", tag, k), r[k], s[k]);
    check({tag, "_passes"}, passes, p);
    check({tag, "_swaps"}, swaps, sw);
    check({tag, "_busy_cycles"}, cyc, mcyc);
    check({tag, "_done_pulses"}, dn, 1);
  endtask

  initial begin
    int v[$], r[$];
    int cyc, dn;
    rst = 1'b1; start = 1'b0; desc = 1'b0; hwe = 1'b0; haddr = '0; hdata = '0;
    start1 = 1'b0; hwe1 = 1'b0; haddr1 = '0; hdata1 = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_passes", passes, 0);
    check("rst_swaps", swaps, 0);
    check("rst_hq", hq, 0);

    v = {};
    for (int k = 0; k < N; k++) v.push_back(N - 1 - k);
    full_test("reverse", v, 1'b0, 0);

    v = {};
    for (int k = 0; k < N; k++) v.push_back(k);
    full_test("sorted", v, 1'b0, 0);

    v = '{3, 7, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    full_test("desc_dup", v, 1'b1, 0);

    v = {};
    for (int k = 0; k < N; k++) v.push_back(N - 1 - k);
    full_test("lockout", v, 1'b0, 10);

    for (int t = 0; t < 6; t++) begin
      bit d;
      v = {};
      d = 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++)
        v.push_back((t % 2) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255)));
      full_test($sformatf("rand%0d", t), v, d, 0);
    end

    v = {};
    for (int k = 0; k < N; k++) v.push_back(N - 1 - k);
    load(v);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    rst = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_passes", passes, 0);
    check("abort_swaps", swaps, 0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) dn++;
      step();
    end
    check("abort_no_done", dn, 0);
    run_sort(1'b0, 0, cyc, dn);
    read_all(r);
    for (int k = 0; k < N; k++) check($sformatf("resume_data%0d", k), r[k], k);
    check("resume_done_pulses", dn, 1);

    haddr1 = 1'b0; hdata1 = 8'd9; hwe1 = 1'b1;
    step();
    haddr1 = 1'b1; hdata1 = 8'd2;
    step();
    hwe1 = 1'b0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    cyc = 0;
    while (busy1 && cyc < 100) begin
      cyc++;
      step();
    end
    check("n2_done", done1, 1);
    check("n2_busy_cycles", cyc, 7);
    check("n2_passes", passes1, 1);
    check("n2_swaps", swaps1, 1);
    haddr1 = 1'b0;
    step();
    step();
    check("n2_data0", hq1, 2);
    haddr1 = 1'b1;
    step();
    step();
    check("n2_data1", hq1, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bubble_sorter.md
# bubble_sorter

Parametrised in-place bubble sorter over an internal W×2^N_LOG2 synchronous RAM. It supports an ascending or descending mode, early exit on a swap-free pass, and a shrinking compare window. A host port loads and reads the array while the block is idle. A START pulse sorts the array, and the block reports BUSY, a one-cycle DONE, and pass/swap statistics. It replaces the fixed 8×16 ascending-only sort device and its button front end; debounce stays outside the block.

## Interface
- W, default 8: data width, W ≥ 1.
- N_LOG2, default 4: log2 of array depth N = 2^N_LOG2, N_LOG2 ≥ 1.
- C  in  1  clock; all state changes on posedge C.
- R  in  1  reset; one clock, synchronous, active-high.
- START  in  1  sort request; sampled only in IDLE.
- DESC  in  1  order: 0 = ascending, 1 = descending; latched on accepted START.
- HWE  in  1  host write enable; honoured only in IDLE.
- HADDR  in  N_LOG2  host address for read and write.
- HDATA  in  W  host write data.
- HQ  out  W  host read data, registered; reset 0.
- BUSY  out  1  sort in progress; reset 0.
- DONE  out  1  one-cycle completion pulse; reset 0.
- PASSES  out  N_LOG2+1  passes executed in the last sort; reset 0.
- SWAPS  out  2·N_LOG2  swaps performed in the last sort; reset 0.

## Operation
- States: IDLE, RD_A, RD_B, LAT, EVAL, WR_A, WR_B, PASS_END.
- IDLE:
  - RAM port is driven by HADDR/HDATA/HWE.
  - HQ is updated with mem[HADDR] every cycle.
  - On START: latch DESC, set i=0, last=N-2, PASSES=0, SWAPS=0, swapped=0, go to RD_A.
- RD_A: present address i.
- RD_B: present address i+1; A ← RAM q (mem[i]).
- LAT: B ← RAM q (mem[i+1]).
- EVAL: out-of-order is A>B when ascending, A<B when descending. Equal values never swap, so the sort is stable.
  - If out of order: set swapped=1, SWAPS+1, go to WR_A.
  - Else if i==last: go to PASS_END.
  - Else: i+1, go to RD_A.
- WR_A: write B to mem[i].
- WR_B: write A to mem[i+1]. Then go to PASS_END if i==last; otherwise i+1 and go to RD_A.
- PASS_END: PASSES+1.
  - If swapped==0 or last==0: go to IDLE and pulse DONE.
  - Else: last−1, i=0, swapped=0, go to RD_A.
- Comparisons are unsigned, W bits.
- The counters cannot overflow: PASSES ≤ N−1 and SWAPS ≤ N(N−1)/2.
- START while BUSY is ignored. HWE while BUSY is ignored. HQ holds its last value while BUSY.
- R at any time:
  - Return to IDLE; all outputs return to their reset values.
  - DONE is not pulsed for an aborted sort.
  - RAM contents are not cleared and may be partially sorted.

## Timing
- RAM read latency is 1 cycle.
- Host read: HADDR at edge k gives HQ=mem[HADDR] after edge k+2.
- Host write with HWE in IDLE commits at the edge. A START in the same cycle is accepted, and the sort sees the written value.
- BUSY rises on the edge that accepts START.
- BUSY falls on the same edge that raises DONE. DONE is high for exactly 1 cycle.
- PASSES and SWAPS are valid while DONE is high and stay held until the next accepted START or R.
- Per pair: 4 cycles without a swap, 6 cycles with a swap. Each pass adds 1 cycle for PASS_END.
- For N=2^N_LOG2, a pass p (0-based) compares N−1−p pairs.
- Already-sorted input: BUSY lasts 4(N−1)+1 cycles, which is 61 for N=16.
- New START is accepted on the first IDLE cycle after DONE.

## Test plan
- Reverse order, W=8, N_LOG2=4: load 15..0, START with DESC=0.
  - Required: array reads 0..15, PASSES=15, SWAPS=120, exactly one DONE pulse.
- Already sorted: load 0..15, START with DESC=0.
  - Required: BUSY high 61 cycles, PASSES=1, SWAPS=0, contents unchanged.
- Descending with duplicates: load 3,7,7,1,0,…,0, START with DESC=1.
  - Required: array reads 7,7,3,1,0,…,0.
  - Equal elements are never exchanged: SWAPS equals the inversion count under the strict comparison.
- Reset mid-sort: load 15..0, START, assert R for 1 cycle at cycle 20.
  - Required: BUSY=0, DONE never pulses, PASSES=SWAPS=0.
  - A following START completes and yields 0..15.
- Busy lockout: during a sort, pulse START and write HWE at HADDR=0 with HDATA=0xFF.
  - Required: no restart, the write is discarded, and the final result excludes 0xFF.
- Boundary, N_LOG2=1: load {9,2}, START.
  - Required: {2,9}, PASSES=1, SWAPS=1, BUSY high 7 cycles.
